// File: rtl/dmem_responder_if.sv
// Word-addressed data-memory bus between the core datapath (master) and the
// memory/IO responder (slave). Reads are combinational from mem_addr.
interface dmem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic        mem_we;
  logic [31:0] mem_read;

  modport master (output mem_addr, output mem_write, output mem_we, input  mem_read);
  modport slave  (input  mem_addr, input  mem_write, input  mem_we, output mem_read);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an IO page with LED register, free-running
// cycle counter and a one-shot down-counting timer with a sticky expiry flag.
module dmem_responder #(
  parameter int unsigned AW    = 8,
  parameter int unsigned LED_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [LED_W-1:0]   leds,
  output logic               tmr_irq
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_CYCLE  = 3'd1;
  localparam logic [2:0] OFF_TLOAD  = 3'd2;
  localparam logic [2:0] OFF_TVAL   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [31:0]      r_ram [DEPTH];
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_cycle;
  logic [31:0]      r_tload;
  logic [31:0]      r_tval;
  logic [0:0]       r_state;
  logic             r_expired;

  logic             w_io_sel;
  logic [2:0]       w_off;
  logic [AW-1:0]    w_ram_idx;
  logic             w_wr_ram;
  logic             w_wr_led;
  logic             w_wr_tload;
  logic             w_wr_status;
  logic [31:0]      w_io_rdata;
  logic [0:0]       w_state_nxt;
  logic [31:0]      w_tval_nxt;
  logic             w_expire;
  logic             w_unused_addr;

  // Address decode: bit 31 picks the IO page; the bits in between alias.
  assign w_io_sel      = bus.mem_addr[31];
  assign w_off         = bus.mem_addr[2:0];
  assign w_ram_idx     = bus.mem_addr[AW-1:0];
  assign w_unused_addr = &{1'b0, bus.mem_addr[30:AW]};

  assign w_wr_ram    = bus.mem_we & ~w_io_sel;
  assign w_wr_led    = bus.mem_we &  w_io_sel & (w_off == OFF_LED);
  assign w_wr_tload  = bus.mem_we &  w_io_sel & (w_off == OFF_TLOAD);
  assign w_wr_status = bus.mem_we &  w_io_sel & (w_off == OFF_STATUS);

  // RAM is never cleared; a store presented while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (reset && w_wr_ram) begin
      r_ram[w_ram_idx] <= bus.mem_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led   <= '0;
      r_cycle <= '0;
      r_tload <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_led) begin
        r_led <= bus.mem_write[LED_W-1:0];
      end
      if (w_wr_tload) begin
        r_tload <= bus.mem_write;
      end
    end
  end

  // Timer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tval  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tval  <= w_tval_nxt;
    end
  end

  // Timer next state: a TLOAD write overrides both countdown and expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_tval_nxt  = r_tval;
    w_expire    = 1'b0;
    if (w_wr_tload) begin
      w_tval_nxt  = bus.mem_write;
      w_state_nxt = (bus.mem_write != 32'd0) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_tval == 32'd1) begin
            w_tval_nxt  = 32'd0;
            w_state_nxt = S_IDLE;
            w_expire    = 1'b1;
          end else begin
            w_tval_nxt  = r_tval - 32'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Sticky expiry flag; a same-cycle expiry beats the write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_expired <= 1'b0;
    end else if (w_expire) begin
      r_expired <= 1'b1;
    end else if (w_wr_status && bus.mem_write[0]) begin
      r_expired <= 1'b0;
    end
  end

  always_comb begin
    w_io_rdata = 32'd0;
    case (w_off)
      OFF_LED:    w_io_rdata = 32'(r_led);
      OFF_CYCLE:  w_io_rdata = r_cycle;
      OFF_TLOAD:  w_io_rdata = r_tload;
      OFF_TVAL:   w_io_rdata = r_tval;
      OFF_STATUS: w_io_rdata = {31'd0, r_expired};
      default:    w_io_rdata = 32'd0;
    endcase
  end

  assign bus.mem_read = w_io_sel ? w_io_rdata : r_ram[w_ram_idx];
  assign leds         = r_led;
  assign tmr_irq      = r_expired;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the memory map.
module tb_dmem_responder;

  logic       clk;
  logic       reset;
  logic [7:0] leds;
  logic       tmr_irq;

  dmem_responder_if bus ();

  dmem_responder #(.AW(8), .LED_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .leds    (leds),
    .tmr_irq (tmr_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit [7:0]  m_led;
  bit [31:0] m_cycle;
  bit [31:0] m_tload;
  bit [31:0] m_tval;
  bit        m_flag;
  bit [31:0] m_ram [int];

  function automatic void model_reset();
    m_led = 0; m_cycle = 0; m_tload = 0; m_tval = 0; m_flag = 0;
  endfunction

  function automatic bit model_known(input bit [31:0] a);
    if (a[31]) return 1'b1;
    return m_ram.exists(int'(a[7:0]));
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] a);
    if (!a[31]) return m_ram[int'(a[7:0])];
    case (a[2:0])
      3'd0: return {24'd0, m_led};
      3'd1: return m_cycle;
      3'd2: return m_tload;
      3'd3: return m_tval;
      3'd4: return {31'd0, m_flag};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_clock(input bit [31:0] a, input bit [31:0] d, input bit we);
    bit io;
    bit set;
    io  = a[31];
    set = 1'b0;
    if (we && !io) m_ram[int'(a[7:0])] = d;
    if (we && io && a[2:0] == 3'd0) m_led = d[7:0];
    if (we && io && a[2:0] == 3'd2) begin
      m_tload = d;
      m_tval  = d;
    end else if (m_tval != 0) begin
      m_tval = m_tval - 1;
      if (m_tval == 0) set = 1'b1;
    end
    if (set) m_flag = 1'b1;
    else if (we && io && a[2:0] == 3'd4 && d[0]) m_flag = 1'b0;
    m_cycle = m_cycle + 1;
  endfunction

  // One clock with the given bus inputs; returns at the following falling edge.
  task automatic drive(input bit [31:0] a, input bit [31:0] d, input bit we);
    bus.mem_addr  = a;
    bus.mem_write = d;
    bus.mem_we    = we;
    @(posedge clk);
    model_clock(a, d, we);
    @(negedge clk);
    bus.mem_we = 1'b0;
  endtask

  task automatic idle();
    drive(32'h8000_0007, 32'd0, 1'b0);
  endtask

  task automatic peek(input bit [31:0] a, output logic [31:0] r);
    bus.mem_addr = a;
    bus.mem_we   = 1'b0;
    #1;
    r = bus.mem_read;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.mem_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0;
    bus.mem_addr = 32'h8000_0000; bus.mem_write = 32'd0; bus.mem_we = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds got=%h exp=00", leds); end
    n_checks++;
    if (tmr_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", tmr_irq); end
    for (int k = 0; k < 3; k++) begin
      peek(32'h8000_0000 | 32'(k + 2), r);
      n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL reset_io%0d got=%h exp=0", k + 2, r); end
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_ram();
    logic [31:0] r;
    drive(32'h0000_0005, 32'hDEAD_BEEF, 1'b1);
    peek(32'h0000_0005, r);
    n_checks++;
    if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd got=%h exp=deadbeef", r); end
    peek(32'h0000_0105, r);
    n_checks++;
    if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias got=%h exp=deadbeef", r); end
    // Read-during-write returns the old word
    bus.mem_addr = 32'h0000_0005; bus.mem_write = 32'h1111_1111; bus.mem_we = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_read !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_rdw got=%h exp=deadbeef", bus.mem_read);
    end
    @(posedge clk);
    model_clock(32'h0000_0005, 32'h1111_1111, 1'b1);
    @(negedge clk);
    peek(32'h4000_0005, r);
    n_checks++;
    if (r !== 32'h1111_1111) begin n_fail++; $display("FAIL ram_new got=%h exp=11111111", r); end
  endtask

  task automatic test_led();
    logic [31:0] r;
    drive(32'h8000_0000, 32'h1234_56A5, 1'b1);
    n_checks++;
    if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_out got=%h exp=a5", leds); end
    peek(32'h8000_0000, r);
    n_checks++;
    if (r !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_rd got=%h exp=000000a5", r); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL led_reset got=%h exp=00", leds); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_timer();
    logic [31:0] r;
    drive(32'h8000_0002, 32'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      peek(32'h8000_0003, r);
      n_checks++;
      if (r !== 32'(3 - k)) begin n_fail++; $display("FAIL tval_step%0d got=%0d exp=%0d", k, r, 3 - k); end
      n_checks++;
      if (tmr_irq !== (k == 3)) begin n_fail++; $display("FAIL irq_step%0d got=%b exp=%b", k, tmr_irq, k == 3); end
      if (k < 3) idle();
    end
    drive(32'h8000_0004, 32'd1, 1'b1);
    n_checks++;
    if (tmr_irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got=%b exp=0", tmr_irq); end
    drive(32'h8000_0002, 32'd0, 1'b1);
    repeat (3) idle();
    peek(32'h8000_0003, r);
    n_checks++;
    if (r !== 32'd0 || tmr_irq !== 1'b0) begin
      n_fail++; $display("FAIL tload_zero got=%0d/%b exp=0/0", r, tmr_irq);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] r;
    drive(32'h8000_0002, 32'd2, 1'b1);
    idle();
    drive(32'h8000_0002, 32'd5, 1'b1);
    peek(32'h8000_0003, r);
    n_checks++;
    if (r !== 32'd5 || tmr_irq !== 1'b0) begin
      n_fail++; $display("FAIL reload_at_one got=%0d/%b exp=5/0", r, tmr_irq);
    end
    repeat (4) idle();
    drive(32'h8000_0004, 32'd1, 1'b1);
    peek(32'h8000_0003, r);
    n_checks++;
    if (tmr_irq !== 1'b1 || r !== 32'd0) begin
      n_fail++; $display("FAIL set_beats_clear got=%b/%0d exp=1/0", tmr_irq, r);
    end
    drive(32'h8000_0004, 32'd1, 1'b1);
  endtask

  task automatic test_cycle();
    logic [31:0] r;
    do_reset();
    repeat (10) idle();
    peek(32'h8000_0001, r);
    n_checks++;
    if (r !== 32'd10) begin n_fail++; $display("FAIL cycle_10 got=%0d exp=10", r); end
    drive(32'h8000_0001, 32'h0000_ABCD, 1'b1);
    peek(32'h8000_0001, r);
    n_checks++;
    if (r !== 32'd11) begin n_fail++; $display("FAIL cycle_wr_ignored got=%0d exp=11", r); end
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    m_cycle = 32'hFFFF_FFFF;
    idle();
    peek(32'h8000_0001, r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL cycle_wrap got=%h exp=0", r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    drive(32'h8000_0000, 32'h0000_003C, 1'b1);
    drive(32'h8000_0002, 32'd1, 1'b1);
    idle();
    drive(32'h8000_0002, 32'd7, 1'b1);
    peek(32'h8000_0003, r);
    n_checks++;
    if (r !== 32'd7 || tmr_irq !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got=%0d/%b exp=7/1", r, tmr_irq);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (tmr_irq !== 1'b0 || leds !== 8'h00) begin
      n_fail++; $display("FAIL arst_outs got=%b/%h exp=0/00", tmr_irq, leds);
    end
    peek(32'h8000_0003, r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL arst_tval got=%0d exp=0", r); end
    peek(32'h0000_0005, r);
    n_checks++;
    if (r !== 32'h1111_1111) begin n_fail++; $display("FAIL arst_ram got=%h exp=11111111", r); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) idle();
    peek(32'h8000_0003, r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL arst_idle got=%0d exp=0", r); end
  endtask

  task automatic test_random();
    bit [31:0] a;
    bit [31:0] d;
    bit        we;
    bit [31:0] exp_rd;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) a = {1'b0, 23'($urandom), 8'($urandom_range(0, 15))};
      else                           a = {1'b1, 28'($urandom), 3'($urandom_range(0, 7))};
      d  = $urandom;
      if (a[31] && a[2:0] == 3'd2) d = 32'($urandom_range(0, 6));
      we = 1'($urandom_range(0, 1));
      bus.mem_addr = a; bus.mem_write = d; bus.mem_we = we;
      #1;
      if (model_known(a)) begin
        exp_rd = model_read(a);
        n_checks++;
        if (bus.mem_read !== exp_rd) begin
          n_fail++; $display("FAIL rand_rd it=%0d addr=%h got=%h exp=%h", i, a, bus.mem_read, exp_rd);
        end
      end
      @(posedge clk);
      model_clock(a, d, we);
      @(negedge clk);
      n_checks++;
      if (leds !== m_led || tmr_irq !== m_flag) begin
        n_fail++; $display("FAIL rand_out it=%0d got=%h/%b exp=%h/%b", i, leds, tmr_irq, m_led, m_flag);
      end
    end
    bus.mem_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_collisions();
    test_cycle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
